fir_valu_sequencer: RTL

FIR_VALU_SEQUENCER -- requirements
Module: fir_valu_sequencer

---
 rtl/fir_valu_sequencer_pkg.sv | 23 ++
 rtl/fir_valu_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fir_valu_sequencer_pkg.sv
// Shared types and constants for the FIR vector-ALU sequencer: state encoding,
// ALU opcodes and default vector geometry.
package fir_valu_sequencer_pkg;

  localparam int unsigned DEF_LANES  = 16;
  localparam int unsigned DEF_LANE_W = 16;
  localparam int unsigned DEF_TAP_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_COEF = 3'd1,
    ST_MUL       = 3'd2,
    ST_ACC       = 3'd3,
    ST_ROT       = 3'd4,
    ST_DONE      = 3'd5
  } seq_state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_VMUL = 3'b011;
  localparam logic [2:0] OP_VROT = 3'b101;

endpackage

// File: rtl/fir_valu_sequencer.sv
// FIR tap sequencer driving an external vector ALU: per coefficient it issues a
// multiply, an accumulate and a window rotation, then holds the result for the consumer.
module fir_valu_sequencer
  import fir_valu_sequencer_pkg::*;
#(
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned LANE_W = DEF_LANE_W,
  parameter int unsigned TAP_W  = DEF_TAP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [TAP_W-1:0]        num_taps,
  input  logic [LANES*LANE_W-1:0] sample_in,
  output logic                    busy,
  input  logic                    coef_valid,
  output logic                    coef_ready,
  input  logic [LANES*LANE_W-1:0] coef_data,
  output logic [LANES*LANE_W-1:0] alu_a,
  output logic [LANES*LANE_W-1:0] alu_b,
  output logic [2:0]              alu_ctrl,
  output logic                    alu_vec_sel,
  input  logic [LANES*LANE_W-1:0] alu_result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [LANES*LANE_W-1:0] result_data
);

  localparam int unsigned VEC_W = LANES * LANE_W;

  seq_state_e       state_r, state_s;
  logic [VEC_W-1:0] window_r, window_s;
  logic [VEC_W-1:0] acc_r, acc_s;
  logic [VEC_W-1:0] prod_r, prod_s;
  logic [VEC_W-1:0] coef_r, coef_s;
  logic [TAP_W-1:0] tap_cnt_r, tap_cnt_s;
  logic [TAP_W-1:0] num_taps_r, num_taps_s;
  logic [TAP_W-1:0] tap_inc_s;

  logic [VEC_W-1:0] alu_a_r, alu_a_s;
  logic [VEC_W-1:0] alu_b_r, alu_b_s;
  logic [2:0]       alu_ctrl_r, alu_ctrl_s;
  logic             alu_vec_sel_r, alu_vec_sel_s;
  logic             busy_r, busy_s;
  logic             coef_ready_r, coef_ready_s;
  logic             result_valid_r, result_valid_s;

  assign tap_inc_s = tap_cnt_r + {{(TAP_W-1){1'b0}}, 1'b1};

  // Next state and datapath register updates
  always_comb begin
    state_s    = state_r;
    window_s   = window_r;
    acc_s      = acc_r;
    prod_s     = prod_r;
    coef_s     = coef_r;
    tap_cnt_s  = tap_cnt_r;
    num_taps_s = num_taps_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          window_s   = sample_in;
          acc_s      = '0;
          tap_cnt_s  = '0;
          num_taps_s = num_taps;
          if (num_taps == {TAP_W{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_WAIT_COEF;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_COEF: begin
        if (coef_valid) begin
          coef_s  = coef_data;
          state_s = ST_MUL;
        end else begin
          state_s = ST_WAIT_COEF;
        end
      end
      ST_MUL: begin
        prod_s  = alu_result;
        state_s = ST_ACC;
      end
      ST_ACC: begin
        acc_s   = alu_result;
        state_s = ST_ROT;
      end
      ST_ROT: begin
        window_s  = alu_result;
        tap_cnt_s = tap_inc_s;
        if (tap_inc_s == num_taps_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT_COEF;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they can be registered yet line up with it
  always_comb begin
    alu_a_s       = '0;
    alu_b_s       = '0;
    alu_ctrl_s    = OP_ADD;
    alu_vec_sel_s = 1'b0;
    case (state_s)
      ST_MUL: begin
        alu_a_s       = window_s;
        alu_b_s       = coef_s;
        alu_ctrl_s    = OP_VMUL;
        alu_vec_sel_s = 1'b1;
      end
      ST_ACC: begin
        alu_a_s       = acc_s;
        alu_b_s       = prod_s;
        alu_ctrl_s    = OP_ADD;
        alu_vec_sel_s = 1'b1;
      end
      ST_ROT: begin
        alu_a_s       = window_s;
        alu_b_s       = '0;
        alu_ctrl_s    = OP_VROT;
        alu_vec_sel_s = 1'b1;
      end
      default: begin
        alu_a_s       = '0;
        alu_b_s       = '0;
        alu_ctrl_s    = OP_ADD;
        alu_vec_sel_s = 1'b0;
      end
    endcase
    busy_s         = (state_s != ST_IDLE);
    coef_ready_s   = (state_s == ST_WAIT_COEF);
    result_valid_s = (state_s == ST_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      window_r       <= '0;
      acc_r          <= '0;
      prod_r         <= '0;
      coef_r         <= '0;
      tap_cnt_r      <= '0;
      num_taps_r     <= '0;
      alu_a_r        <= '0;
      alu_b_r        <= '0;
      alu_ctrl_r     <= OP_ADD;
      alu_vec_sel_r  <= 1'b0;
      busy_r         <= 1'b0;
      coef_ready_r   <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      window_r       <= window_s;
      acc_r          <= acc_s;
      prod_r         <= prod_s;
      coef_r         <= coef_s;
      tap_cnt_r      <= tap_cnt_s;
      num_taps_r     <= num_taps_s;
      alu_a_r        <= alu_a_s;
      alu_b_r        <= alu_b_s;
      alu_ctrl_r     <= alu_ctrl_s;
      alu_vec_sel_r  <= alu_vec_sel_s;
      busy_r         <= busy_s;
      coef_ready_r   <= coef_ready_s;
      result_valid_r <= result_valid_s;
    end
  end

  assign busy         = busy_r;
  assign coef_ready   = coef_ready_r;
  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_ctrl     = alu_ctrl_r;
  assign alu_vec_sel  = alu_vec_sel_r;
  assign result_valid = result_valid_r;
  // The accumulator only moves in ACC, so it is stable for the whole DONE hold
  assign result_data  = acc_r;

endmodule
